// File: rtl/pl_bram_wr.sv
// Writes a stream of 32-bit words into a BRAM port as one burst per rising edge of start_wr.
// The burst length is checked on acceptance, and every output is driven from a flop.
module pl_bram_wr #(
  parameter logic [31:0] MAX_LEN = 32'd8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_wr,
  input  logic [31:0] start_addr,
  input  logic [31:0] wr_len,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        err_len,
  output logic        ram_clk,
  output logic        ram_rst,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wr_data
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t      state_q;
  logic        d0_q, d1_q;
  logic [31:0] base_q, count_q, idx_q;
  logic        s_ready_q, busy_q, done_q, err_q, en_q;
  logic [3:0]  we_q;
  logic [31:0] addr_q, wdata_q;

  logic        pos_start, len_ok, beat, last_beat;
  logic [31:0] addr_d;

  always_comb begin
    pos_start = d0_q & ~d1_q;
    len_ok    = (wr_len != '0) && (wr_len[1:0] == 2'b00) && (wr_len <= MAX_LEN);
    beat      = s_valid & s_ready_q;
    last_beat = (idx_q == count_q - 32'd1);
    addr_d    = base_q + {idx_q[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      d0_q      <= 1'b0;
      d1_q      <= 1'b0;
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      d0_q   <= start_wr;
      d1_q   <= d0_q;
      // Strobes default low; address and data hold between writes.
      en_q   <= 1'b0;
      we_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pos_start) begin
            if (len_ok) begin
              state_q   <= WRITE;
              base_q    <= start_addr;
              count_q   <= {2'b00, wr_len[31:2]};
              idx_q     <= '0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (beat) begin
            en_q    <= 1'b1;
            we_q    <= '1;
            addr_q  <= addr_d;
            wdata_q <= s_data;
            idx_q   <= idx_q + 32'd1;
            if (last_beat) begin
              state_q   <= DONE;
              s_ready_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_len     = err_q;
  assign ram_clk     = clk;
  assign ram_rst     = 1'b0;
  assign ram_en      = en_q;
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wr_data = wdata_q;

endmodule

// File: tb/tb_pl_bram_wr.sv
// Scoreboard bench for pl_bram_wr: stimulus queues expected BRAM writes, and a monitor pops
// and checks them whenever ram_en or done is seen.
module tb_pl_bram_wr;

  localparam logic [31:0] TB_MAX = 32'd64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_wr;
  logic [31:0] start_addr, wr_len, s_data;
  logic        s_valid;
  logic        s_ready, busy, done, err_len, ram_clk, ram_rst, ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wr_data;

  pl_bram_wr #(.MAX_LEN(TB_MAX)) dut (
    .clk(clk), .rst(rst), .start_wr(start_wr), .start_addr(start_addr), .wr_len(wr_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .done(done),
    .err_len(err_len), .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned total = 0, bad = 0;
  int unsigned cyc_cnt = 0, done_cnt = 0, err_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the queue, including its cycle and done flag.
  initial begin
    wr_t  e;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_prev) chk("busy_after_done", 32'(busy), 32'd0);
      if (done) done_cnt++;
      if (err_len) err_cnt++;
      if (ram_en || done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'({ram_en, done}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_en", 32'(ram_en), 32'd1);
          chk("wr_we", 32'(ram_we), 32'hF);
          chk("wr_addr", ram_addr, e.addr);
          chk("wr_data", ram_wr_data, e.data);
          chk("wr_done", 32'(done), 32'(e.last));
          chk("wr_cycle", cyc_cnt, e.cyc);
        end
      end
      done_prev = done;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 32'({s_ready, busy, done, err_len, ram_en, ram_we, ram_rst}), 32'd0);
    chk({tag, "_addr"}, ram_addr, 32'd0);
    chk({tag, "_data"}, ram_wr_data, 32'd0);
  endtask

  // Starts a burst of `words` words and feeds `feed` of them; vmask bit n gates the n-th ready slot.
  task automatic run_burst(input string tag, input logic [31:0] addr, input int unsigned words,
                           input int unsigned feed, input logic [31:0] vmask, input bit toggle);
    int unsigned i = 0, slot = 0, cyc = 0;
    wr_t e;
    @(negedge clk);
    start_addr = addr;
    wr_len     = words * 4;
    start_wr   = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_early"}, 32'(s_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_ready_start"}, 32'(s_ready), 32'd1);
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (i < feed && cyc < 200) begin
      s_valid = 1'b0;
      if (s_ready) begin
        if (vmask[slot % 32]) begin
          s_valid = 1'b1;
          s_data  = 32'hA5C3_0000 ^ addr ^ i;
          e.addr  = addr + i * 4;
          e.data  = s_data;
          e.last  = (i == words - 1);
          e.cyc   = cyc_cnt + 1;
          exp_q.push_back(e);
          i++;
        end
        slot++;
      end
      start_wr = toggle && (cyc % 2 == 1) && (cyc < 4);
      @(negedge clk);
      cyc++;
    end
    s_valid  = 1'b0;
    start_wr = 1'b0;
    if (i < feed) chk({tag, "_timeout"}, i, feed);
    if (feed == words) begin
      cyc = 0;
      while (busy && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic bad_start(input string tag, input logic [31:0] len);
    @(negedge clk);
    wr_len     = len;
    start_addr = 32'h40;
    start_wr   = 1'b1;
    @(negedge clk);
    chk({tag, "_err_early"}, 32'({err_len, busy}), 32'd0);
    @(negedge clk);
    chk({tag, "_err_pulse"}, 32'({err_len, busy, s_ready}), 32'b100);
    start_wr = 1'b0;
    @(negedge clk);
    chk({tag, "_err_end"}, 32'({err_len, busy}), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int unsigned d0, e0;
    rst = 1'b1; start_wr = 1'b0; s_valid = 1'b0; s_data = '0; start_addr = '0; wr_len = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    d0 = done_cnt;
    run_burst("b16", 32'h0, 4, 4, '1, 1'b0);
    chk("b16_done", done_cnt - d0, 32'd1);

    d0 = done_cnt;
    run_burst("stall", 32'h200, 2, 2, 32'hFFFF_FFF9, 1'b0);
    chk("stall_done", done_cnt - d0, 32'd1);

    e0 = err_cnt;
    bad_start("len0", 32'd0);
    bad_start("len6", 32'd6);
    bad_start("lenmax4", TB_MAX + 32'd4);
    chk("illegal_err_count", err_cnt - e0, 32'd3);

    d0 = done_cnt; e0 = err_cnt;
    run_burst("max", 32'h2000, TB_MAX / 4, TB_MAX / 4, '1, 1'b0);
    chk("max_done", done_cnt - d0, 32'd1);
    chk("max_no_err", err_cnt - e0, 32'd0);

    d0 = done_cnt; e0 = err_cnt;
    run_burst("restart", 32'h1000, 8, 8, '1, 1'b1);
    chk("restart_done", done_cnt - d0, 32'd1);
    chk("restart_no_err", err_cnt - e0, 32'd0);

    d0 = done_cnt;
    run_burst("midrst", 32'h300, 4, 2, '1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    chk("midrst_queue", exp_q.size(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    run_burst("post", 32'h100, 1, 1, '1, 1'b0);
    chk("post_done", done_cnt - d0, 32'd1);

    d0 = done_cnt;
    run_burst("wrap", 32'hFFFF_FFF8, 4, 4, '1, 1'b0);
    chk("wrap_done", done_cnt - d0, 32'd1);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("err_total", err_cnt, 32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pl_bram_wr.md
PL_BRAM_WR -- requirements
Module: pl_bram_wr

Interface
REQ-001 Parameter MAX_LEN, default 32'd8192: largest legal wr_len in bytes (BRAM depth).
REQ-002 clk  input  1  single clock; all logic on rising edge; ram_clk = clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start_wr  input  1  level from PS; each rising edge requests one write burst.
REQ-005 start_addr  input  32  byte address of the first word; sampled on the accepted start.
REQ-006 wr_len  input  32  burst length in bytes; sampled on the accepted start.
REQ-007 s_data  input  32  upstream write data word.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  block accepts a word; a beat transfers when s_valid & s_ready at a clock edge.
REQ-010 busy  output  1  high while a burst is in progress.
REQ-011 done  output  1  one-cycle pulse at burst completion.
REQ-012 err_len  output  1  one-cycle pulse when a start is rejected.
REQ-013 ram_clk  output  1  equals clk.
REQ-014 ram_rst  output  1  constant 0.
REQ-015 ram_en  output  1  BRAM port enable.
REQ-016 ram_we  output  4  byte write enables.
REQ-017 ram_addr  output  32  BRAM byte address.
REQ-018 ram_wr_data  output  32  BRAM write data.

Function
REQ-019 start_wr shall pass through two flops (d0, d1); pos_start = d0 & ~d1.
REQ-020 FSM states: IDLE, WRITE, DONE.
REQ-021 IDLE + pos_start + legal wr_len -> WRITE at the next edge. Latch start_addr and wr_len/4 as the word count. Clear the word index.
REQ-022 wr_len is legal when it is nonzero, wr_len[1:0]==0, and wr_len <= MAX_LEN.
REQ-023 IDLE + pos_start + illegal wr_len -> stay IDLE. err_len = 1 for exactly one cycle. No BRAM access.
REQ-024 Start latency: start_wr first sampled high at edge k (low at k-1) -> FSM enters WRITE at edge k+1; s_ready = 1 from then.
REQ-025 s_ready = 1 only in WRITE; it shall not depend combinationally on s_valid.
REQ-026 Each beat accepted at edge j (word index i): in the cycle after edge j, drive ram_en = 1, ram_we = 4'hF, ram_addr = start_addr + 4*i, ram_wr_data = s_data. All outputs are registered.
REQ-027 In any cycle without an accepted beat, ram_en = 0 and ram_we = 0. ram_addr and ram_wr_data hold their values.
REQ-028 s_valid low in WRITE stalls the burst with no write. There is no timeout.
REQ-029 Acceptance of the last word (index = count-1) at edge j -> DONE at edge j. s_ready = 0 after edge j.
REQ-030 DONE lasts one cycle: done = 1 concurrent with the final BRAM write, then -> IDLE.
REQ-031 busy = 1 in WRITE and DONE, 0 in IDLE.
REQ-032 pos_start while not in IDLE is ignored: no err_len, no restart.
REQ-033 Address arithmetic is 32-bit modulo 2^32. start_addr + 4*i wraps silently past 32'hFFFF_FFFC.
REQ-034 start_addr[1:0] passes to ram_addr unmodified; alignment is the PS's responsibility.
REQ-035 The word count shall be 32 bits wide; the index compare shall be exact equality.

Reset
REQ-036 When rst is high at an edge: state = IDLE; d0 = d1 = 0; s_ready, busy, done, err_len, ram_en = 0; ram_we = 4'h0; ram_addr = 32'h0; ram_wr_data = 32'h0.
REQ-037 Reset mid-burst abandons the burst; no further writes occur and done is not asserted.
REQ-038 A start_wr held high through reset release counts as a new rising edge (d0 = 1, d1 = 0 after release).

Verification
REQ-039 Burst: start_addr = 0, wr_len = 16, s_valid held 1 with data A0..A3 -> four writes at addr 0, 4, 8, 12 on consecutive cycles, ram_we = F; done high on the addr-12 cycle; busy low the cycle after.
REQ-040 Stall: wr_len = 8, s_valid pattern 1,0,0,1 -> writes at addr base and base+4 separated by two idle cycles (ram_en = 0); a single done pulse.
REQ-041 Illegal length: wr_len = 0, then 6, then MAX_LEN+4 -> err_len pulses once per start; ram_en never 1; busy stays 0.
REQ-042 Restart ignored: start_wr toggled 0-1-0-1 during a 32-byte burst -> exactly 8 writes; one done; no err_len.
REQ-043 Reset mid-burst: rst = 1 after 2 of 4 words -> all outputs 0 at the next edge; no done; a fresh 4-byte burst afterwards writes 1 word correctly.
REQ-044 Wrap: start_addr = 32'hFFFF_FFF8, wr_len = 16 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
